seg7_scan_display: RTL and testbench

SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

---
 rtl/seg7_scan_display.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_display.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment scanner for two-digit time fields.
// Snapshots the selected source once per frame; blink/leading-zero applied per digit.
module seg7_scan_display #(
  parameter int NSRC      = 4,
  parameter int NFIELD    = 3,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000,
  localparam int SW       = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NSRC*NFIELD*8-1:0] src_data,
  input  logic [SW-1:0]            sel,
  input  logic [NFIELD-1:0]        blink_mask,
  input  logic                     lz_blank,
  output logic [6:0]               seg_out,
  output logic [2*NFIELD-1:0]      dig_en,
  output logic                     frame_tick
);

  localparam int FW = NFIELD * 8;
  localparam int ND = 2 * NFIELD;
  localparam int IW = $clog2(ND);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'h3F;

  logic [PW-1:0] r_pre;
  logic [IW-1:0] r_idx;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic [FW-1:0] r_snap;
  logic          r_blank;
  logic          r_wrap;

  logic          w_tc;
  logic          w_last;
  logic          w_btc;
  logic          w_oor;
  logic [FW-1:0] w_src;
  logic [IW-1:0] w_fi;
  logic          w_tens;
  logic          w_top;
  logic [7:0]    w_val;
  logic          w_blk;
  logic [3:0]    w_digit;
  logic [6:0]    w_code;
  logic [6:0]    w_seg;
  logic [ND-1:0] w_den;

  assign w_tc   = r_pre == PW'(SCAN_DIV - 1);
  assign w_last = r_idx == IW'(ND - 1);
  assign w_btc  = r_bcnt == BW'(BLINK_DIV - 1);
  assign w_oor  = {1'b0, sel} >= (SW+1)'(NSRC);
  assign w_fi   = r_idx >> 1;
  assign w_tens = r_idx[0];
  assign w_top  = w_fi == IW'(NFIELD - 1);
  assign w_den  = ~(ND'(1) << r_idx);

  // explicit mux keeps an out-of-range sel from indexing past src_data
  always_comb begin
    w_src = '0;
    for (int k = 0; k < NSRC; k++)
      if ({1'b0, sel} == (SW+1)'(k))
        w_src = src_data[k*FW +: FW];
  end

  always_comb begin
    w_val = '0;
    w_blk = 1'b0;
    for (int f = 0; f < NFIELD; f++)
      if (w_fi == IW'(f)) begin
        w_val = r_snap[f*8 +: 8];
        w_blk = blink_mask[f];
      end
  end

  assign w_digit = w_tens ? 4'(w_val / 8'd10) : 4'(w_val % 8'd10);

  always_comb begin
    w_code = BLANK;
    unique case (w_digit)
      4'd0: w_code = 7'h40;
      4'd1: w_code = 7'h79;
      4'd2: w_code = 7'h24;
      4'd3: w_code = 7'h30;
      4'd4: w_code = 7'h19;
      4'd5: w_code = 7'h12;
      4'd6: w_code = 7'h02;
      4'd7: w_code = 7'h78;
      4'd8: w_code = 7'h00;
      4'd9: w_code = 7'h10;
      default: w_code = BLANK;
    endcase
  end

  // precedence: bad source > blink > dash > leading zero > digit
  always_comb begin
    w_seg = w_code;
    if (r_blank)
      w_seg = BLANK;
    else if (r_phase && w_blk)
      w_seg = BLANK;
    else if (w_val > 8'd99)
      w_seg = DASH;
    else if (lz_blank && w_top && w_tens && w_digit == 4'd0)
      w_seg = BLANK;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pre      <= '0;
      r_idx      <= '0;
      r_bcnt     <= '0;
      r_phase    <= 1'b0;
      r_snap     <= '0;
      r_blank    <= 1'b0;
      r_wrap     <= 1'b0;
      seg_out    <= BLANK;
      dig_en     <= '1;
      frame_tick <= 1'b0;
    end else begin
      r_pre <= w_tc ? '0 : r_pre + 1'b1;
      if (w_tc) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          r_snap  <= w_src;
          r_blank <= w_oor;
        end
      end
      r_bcnt <= w_btc ? '0 : r_bcnt + 1'b1;
      if (w_btc)
        r_phase <= ~r_phase;
      r_wrap     <= w_tc && w_last;
      frame_tick <= r_wrap;
      seg_out    <= w_seg;
      dig_en     <= w_den;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display.
// SCAN_DIV=4, BLINK_DIV=16, NFIELD=3, NSRC=3: one frame = 24 clocks.
module tb_seg7_scan_display;

  logic        clock = 1'b0;
  logic        reset;
  logic [71:0] src_data;
  logic [1:0]  sel;
  logic [2:0]  blink_mask;
  logic        lz_blank;
  logic [6:0]  seg_out;
  logic [5:0]  dig_en;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  seg7_scan_display #(
    .NSRC(3), .NFIELD(3), .SCAN_DIV(4), .BLINK_DIV(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .src_data(src_data),
    .sel(sel),
    .blink_mask(blink_mask),
    .lz_blank(lz_blank),
    .seg_out(seg_out),
    .dig_en(dig_en),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  // digit k of frame n is on the outputs after edges 24n+4k+1..24n+4k+4
  task automatic chk_digs(input string tag, input int n, input int k0,
                          input int k1, input logic [6:0] e [6]);
    for (int k = k0; k <= k1; k++) begin
      goto(24*n + 4*k + 2);
      chk($sformatf("%s_seg%0d", tag, k), 32'(seg_out), 32'(e[k]));
      chk($sformatf("%s_den%0d", tag, k), 32'(dig_en),
          32'(6'(~(6'd1 << k))));
    end
  endtask

  logic [6:0] base [6];
  logic [6:0] ex;
  int         kk;

  initial begin
    reset      = 1'b0;
    src_data   = '0;
    sel        = 2'd0;
    blink_mask = 3'b000;
    lz_blank   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_seg", 32'(seg_out), 32'h7F);
    chk("rst_den", 32'(dig_en), 32'h3F);
    chk("rst_tick", 32'(frame_tick), 32'h0);

    reset = 1'b1;
    cyc   = 0;
    goto(1);
    chk("first_seg", 32'(seg_out), 32'h40);
    chk("first_den", 32'(dig_en), 32'h3E);

    src_data = {24'h070A03, 24'h0C1F40, 24'h172D05};
    goto(24);
    chk("tick_pre", 32'(frame_tick), 32'h0);
    goto(25);
    chk("tick_wrap", 32'(frame_tick), 32'h1);
    goto(26);
    chk("tick_post", 32'(frame_tick), 32'h0);

    // 23:45:05
    chk_digs("f1", 1, 0, 3,
      '{7'h12, 7'h40, 7'h12, 7'h19, 7'h30, 7'h24});
    sel = 2'd1;
    src_data[15:8] = 8'h64;
    chk_digs("f1b", 1, 4, 5,
      '{7'h12, 7'h40, 7'h12, 7'h19, 7'h30, 7'h24});
    goto(48);
    chk("tick2_pre", 32'(frame_tick), 32'h0);
    goto(49);
    chk("tick2", 32'(frame_tick), 32'h1);
    goto(50);
    chk("tick2_post", 32'(frame_tick), 32'h0);

    // source 1: 12:31:64
    chk_digs("f2", 2, 0, 5,
      '{7'h19, 7'h02, 7'h79, 7'h30, 7'h24, 7'h79});
    sel = 2'd0;

    // seconds 05, minutes 100 -> dash
    chk_digs("f3", 3, 0, 3,
      '{7'h12, 7'h40, 7'h3F, 7'h3F, 7'h30, 7'h24});
    src_data[15:8] = 8'h2D;
    blink_mask     = 3'b010;
    chk_digs("f3b", 3, 4, 5,
      '{7'h12, 7'h40, 7'h3F, 7'h3F, 7'h30, 7'h24});

    // blink phase seen on seg_out after edge c is ((c-1)/16) odd
    base = '{7'h12, 7'h40, 7'h12, 7'h19, 7'h30, 7'h24};
    for (int c = 97; c <= 168; c++) begin
      goto(c);
      kk = ((c - 1) % 24) / 4;
      ex = base[kk];
      if (kk / 2 == 1 && ((c - 1) / 16) % 2 == 1)
        ex = 7'h7F;
      chk($sformatf("blink_c%0d", c), 32'(seg_out), 32'(ex));
    end
    blink_mask = 3'b000;

    goto(170);
    sel = 2'd3;
    chk_digs("oor", 8, 0, 5,
      '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
    sel      = 2'd2;
    lz_blank = 1'b1;

    // source 2: 07:10:03, only the top tens zero is blanked
    chk_digs("lz", 9, 0, 5,
      '{7'h30, 7'h40, 7'h40, 7'h79, 7'h78, 7'h7F});

    goto(250);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("mrst_seg", 32'(seg_out), 32'h7F);
    chk("mrst_den", 32'(dig_en), 32'h3F);
    chk("mrst_tick", 32'(frame_tick), 32'h0);
    reset = 1'b1;
    cyc   = 0;
    goto(1);
    chk("rel_seg", 32'(seg_out), 32'h40);
    chk("rel_den", 32'(dig_en), 32'h3E);
    goto(5);
    chk("rel_seg1", 32'(seg_out), 32'h40);
    chk("rel_den1", 32'(dig_en), 32'h3D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
